// File: rtl/fetch_stall_ctrl.sv
// PC and IF/ID register owner: applies hazard hold/bubble, branch flush, stall watchdog.
// Optional STALL_PERF_CNT_EN adds Stall_Cycles / Flush_Count counters.
module fetch_stall_ctrl #(
   parameter int unsigned PC_WIDTH    = 64,
   parameter int unsigned INSTR_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
   parameter int unsigned MAX_STALL   = 4
) (
   input  logic                   CLOCK,
   input  logic                   RESET_N,
   input  logic                   PCWire,
   input  logic                   IFID_Write,
   input  logic                   ControlWire,
   input  logic                   Branch_Taken,
   input  logic [PC_WIDTH-1:0]    Branch_Target,
   input  logic [INSTR_WIDTH-1:0] Instr_In,
   output logic [PC_WIDTH-1:0]    PC_Out,
   output logic [PC_WIDTH-1:0]    IFID_PC,
   output logic [INSTR_WIDTH-1:0] IFID_Instr,
   output logic                   IFID_Valid,
   output logic                   IDEX_CtrlEnable,
   output logic                   Stall_Timeout
`ifdef STALL_PERF_CNT_EN
   ,
   output logic [31:0]            Stall_Cycles,
   output logic [31:0]            Flush_Count
`endif
);

   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

   localparam logic [7:0] MaxCnt = 8'(MAX_STALL);

   state_t state, stateNext;
   logic [7:0] stallCnt, cntNext;
   logic [PC_WIDTH-1:0] pcNext, ifidPcNext;
   logic [INSTR_WIDTH-1:0] ifidInstrNext;
   logic ifidValidNext, timeoutNext;
   logic bothLow, wdFire, stallHold, pcAdv;

   assign bothLow = !PCWire && !IFID_Write;

   // Mutually exclusive so the one-hot decode below stays unique.
   assign wdFire = !Branch_Taken && (state == STALL)
                   && bothLow && (stallCnt >= MaxCnt);
   assign stallHold = !Branch_Taken && (state == STALL)
                      && bothLow && (stallCnt < MaxCnt);

   always_comb begin
      stateNext     = state;
      cntNext       = stallCnt;
      pcNext        = PC_Out;
      ifidPcNext    = IFID_PC;
      ifidInstrNext = IFID_Instr;
      ifidValidNext = IFID_Valid;
      timeoutNext   = Stall_Timeout;
      pcAdv         = 1'b0;
      unique case (1'b1)
         Branch_Taken: begin
            pcNext        = Branch_Target;
            ifidInstrNext = '0;
            ifidValidNext = 1'b0;
            cntNext       = '0;
            stateNext     = FLUSH;
            pcAdv         = 1'b1;
         end
         wdFire: begin
            pcNext        = PC_Out + PC_WIDTH'(4);
            ifidPcNext    = PC_Out;
            ifidInstrNext = Instr_In;
            ifidValidNext = 1'b1;
            timeoutNext   = 1'b1;
            cntNext       = '0;
            stateNext     = RUN;
            pcAdv         = 1'b1;
         end
         stallHold: begin
            cntNext = stallCnt + 8'd1;
         end
         default: begin
            if (PCWire) begin
               pcNext = PC_Out + PC_WIDTH'(4);
               pcAdv  = 1'b1;
            end
            if (IFID_Write) begin
               ifidPcNext    = PC_Out;
               ifidInstrNext = Instr_In;
               ifidValidNext = (state != FLUSH);
            end
            if (state == RUN && bothLow) begin
               stateNext = STALL;
               cntNext   = 8'd1;
            end else begin
               stateNext = RUN;
               cntNext   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state         <= RUN;
         stallCnt      <= '0;
         PC_Out        <= RESET_PC;
         IFID_PC       <= '0;
         IFID_Instr    <= '0;
         IFID_Valid    <= 1'b0;
         Stall_Timeout <= 1'b0;
      end else begin
         state         <= stateNext;
         stallCnt      <= cntNext;
         PC_Out        <= pcNext;
         IFID_PC       <= ifidPcNext;
         IFID_Instr    <= ifidInstrNext;
         IFID_Valid    <= ifidValidNext;
         Stall_Timeout <= timeoutNext;
      end
   end

   assign IDEX_CtrlEnable = ControlWire && IFID_Valid && (state != FLUSH);

`ifdef STALL_PERF_CNT_EN
   // A stall cycle is any edge on which the PC fails to move.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         Stall_Cycles <= '0;
         Flush_Count  <= '0;
      end else begin
         if (!pcAdv && Stall_Cycles != 32'hFFFF_FFFF)
            Stall_Cycles <= Stall_Cycles + 32'd1;
         if (Branch_Taken && Flush_Count != 32'hFFFF_FFFF)
            Flush_Count <= Flush_Count + 32'd1;
      end
   end
`else
   logic unusedAdv;
   assign unusedAdv = pcAdv;
`endif

endmodule
